// File: rtl/xor_accum.sv
// Streaming XOR-reduction engine: folds each frame's words into a checksum and
// presents sum, parity, word count and overflow on a valid/ready result port.
module xor_accum #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    parameter int ODD       = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_sum,
    output logic                             out_parity,
    output logic [$clog2(MAX_WORDS+1)-1:0]   out_count,
    output logic                             out_overflow
);

    localparam int             CW    = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0]  MAXW  = CW'(MAX_WORDS);
    localparam logic           ODD_B = (ODD != 0);

    typedef enum logic {ACCUM, HOLD} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             par_q, par_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt_inc;
    logic             word_xfer;
    logic             closing;

    assign acc_next  = acc_q ^ in_data;
    assign cnt_inc   = cnt_q + 1'b1;
    assign word_xfer = in_valid && (state_q == ACCUM);
    assign closing   = in_last || (cnt_inc == MAXW);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            par_q   <= ODD_B;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            par_q   <= par_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath: result registers only load on the closing word.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        par_d   = par_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACCUM: begin
                if (word_xfer) begin
                    if (closing) begin
                        sum_d   = acc_next;
                        par_d   = (^acc_next) ^ ODD_B;
                        count_d = cnt_inc;
                        ovf_d   = !in_last;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        acc_d = acc_next;
                        cnt_d = cnt_inc;
                    end
                end
            end
            HOLD: begin
                if (out_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        in_ready     = (state_q == ACCUM);
        out_valid    = (state_q == HOLD);
        out_sum      = sum_q;
        out_parity   = par_q;
        out_count    = count_q;
        out_overflow = ovf_q;
    end

endmodule

// File: tb/tb_xor_accum.sv
// Directed bench for xor_accum: a per-cycle vector table on the default-style
// configuration plus short hand sequences for odd parity and a 2-bit variant.
module tb_xor_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: WIDTH=8, MAX_WORDS=4, ODD=0
    logic       rst0, v0, rdy0, last0, ov0, ordy0, par0, ovf0;
    logic [7:0] data0, sum0;
    logic [2:0] cnt0;
    // DUT 1: WIDTH=8, MAX_WORDS=4, ODD=1
    logic       rst1, v1, rdy1, last1, ov1, ordy1, par1, ovf1;
    logic [7:0] data1, sum1;
    logic [2:0] cnt1;
    // DUT 2: WIDTH=2, MAX_WORDS=2, ODD=0
    logic       rst2, v2, rdy2, last2, ov2, ordy2, par2, ovf2;
    logic [1:0] data2, sum2;
    logic [1:0] cnt2;

    xor_accum #(.WIDTH(8), .MAX_WORDS(4), .ODD(0)) u0 (
        .clk(clk), .rst(rst0), .in_valid(v0), .in_ready(rdy0), .in_data(data0),
        .in_last(last0), .out_valid(ov0), .out_ready(ordy0), .out_sum(sum0),
        .out_parity(par0), .out_count(cnt0), .out_overflow(ovf0));

    xor_accum #(.WIDTH(8), .MAX_WORDS(4), .ODD(1)) u1 (
        .clk(clk), .rst(rst1), .in_valid(v1), .in_ready(rdy1), .in_data(data1),
        .in_last(last1), .out_valid(ov1), .out_ready(ordy1), .out_sum(sum1),
        .out_parity(par1), .out_count(cnt1), .out_overflow(ovf1));

    xor_accum #(.WIDTH(2), .MAX_WORDS(2), .ODD(0)) u2 (
        .clk(clk), .rst(rst2), .in_valid(v2), .in_ready(rdy2), .in_data(data2),
        .in_last(last2), .out_valid(ov2), .out_ready(ordy2), .out_sum(sum2),
        .out_parity(par2), .out_count(cnt2), .out_overflow(ovf2));

    typedef struct {
        logic       rst, v;
        logic [7:0] d;
        logic       last, ordy;
        logic       ov, ir;
        logic [7:0] sum;
        logic       par;
        logic [2:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic l, logic o,
                                logic eov, logic eir, logic [7:0] es, logic ep,
                                logic [2:0] ec, logic eof);
        vec_t t;
        t.rst = r; t.v = v; t.d = d; t.last = l; t.ordy = o;
        t.ov = eov; t.ir = eir; t.sum = es; t.par = ep; t.cnt = ec; t.ovf = eof;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send2(input logic [1:0] d, input logic l);
        v2 = 1'b1; data2 = d; last2 = l;
        tick();
        v2 = 1'b0; data2 = '0; last2 = 1'b0;
    endtask

    initial begin
        rst0 = 1'b1; v0 = 1'b0; data0 = '0; last0 = 1'b0; ordy0 = 1'b1;
        rst1 = 1'b1; v1 = 1'b0; data1 = '0; last1 = 1'b0; ordy1 = 1'b1;
        rst2 = 1'b1; v2 = 1'b0; data2 = '0; last2 = 1'b0; ordy2 = 1'b1;

        //                rst v  data   last ordy | ov ir  sum   par cnt ovf
        tbl.push_back(mk(1, 0, 8'h00, 0, 1,   0, 1, 8'h00, 0, 0, 0)); // reset state
        tbl.push_back(mk(0, 1, 8'hA5, 0, 1,   0, 1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h5A, 0, 1,   0, 1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hFF, 1, 1,   1, 0, 8'h00, 0, 3, 0));
        tbl.push_back(mk(0, 1, 8'h77, 0, 1,   0, 1, 8'h00, 0, 3, 0)); // ignored in HOLD
        tbl.push_back(mk(0, 1, 8'h01, 1, 1,   1, 0, 8'h01, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1,   0, 1, 8'h01, 1, 1, 0));
        tbl.push_back(mk(0, 1, 8'h11, 0, 1,   0, 1, 8'h01, 1, 1, 0));
        tbl.push_back(mk(0, 1, 8'h22, 0, 1,   0, 1, 8'h01, 1, 1, 0));
        tbl.push_back(mk(0, 1, 8'h44, 0, 1,   0, 1, 8'h01, 1, 1, 0));
        tbl.push_back(mk(0, 1, 8'h88, 0, 1,   1, 0, 8'hFF, 0, 4, 1)); // forced close
        tbl.push_back(mk(0, 0, 8'h00, 0, 1,   0, 1, 8'hFF, 0, 4, 1));
        tbl.push_back(mk(0, 1, 8'h03, 1, 1,   1, 0, 8'h03, 0, 1, 0)); // fresh acc
        tbl.push_back(mk(0, 0, 8'h00, 0, 1,   0, 1, 8'h03, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'h0F, 0, 0,   0, 1, 8'h03, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'hF0, 1, 0,   1, 0, 8'hFF, 0, 2, 0));
        for (int i = 0; i < 5; i++)                                     // back-pressure
            tbl.push_back(mk(0, 1, 8'hAB, 1, 0, 1, 0, 8'hFF, 0, 2, 0));
        tbl.push_back(mk(0, 1, 8'hAB, 1, 1,   0, 1, 8'hFF, 0, 2, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0,   0, 1, 8'hFF, 0, 2, 0));
        tbl.push_back(mk(0, 1, 8'h55, 0, 1,   0, 1, 8'hFF, 0, 2, 0));
        tbl.push_back(mk(0, 1, 8'hAA, 0, 1,   0, 1, 8'hFF, 0, 2, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 1,   0, 1, 8'h00, 0, 0, 0)); // mid-frame reset
        tbl.push_back(mk(0, 1, 8'h0F, 1, 0,   1, 0, 8'h0F, 0, 1, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0,   0, 1, 8'h00, 0, 0, 0)); // reset in HOLD
        tbl.push_back(mk(0, 1, 8'h0C, 1, 1,   1, 0, 8'h0C, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1,   0, 1, 8'h0C, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'h01, 0, 1,   0, 1, 8'h0C, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'h02, 0, 1,   0, 1, 8'h0C, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'h04, 0, 1,   0, 1, 8'h0C, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'h08, 1, 1,   1, 0, 8'h0F, 0, 4, 0)); // last at limit
        tbl.push_back(mk(0, 0, 8'h00, 0, 1,   0, 1, 8'h0F, 0, 4, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            rst0 = tbl[i].rst; v0 = tbl[i].v; data0 = tbl[i].d;
            last0 = tbl[i].last; ordy0 = tbl[i].ordy;
            tick();
            if (i == 0) begin
                rst1 = 1'b0;
                rst2 = 1'b0;
            end
            chk($sformatf("vec%0d", i),
                {17'd0, ov0, rdy0, sum0, par0, cnt0, ovf0},
                {17'd0, tbl[i].ov, tbl[i].ir, tbl[i].sum, tbl[i].par, tbl[i].cnt, tbl[i].ovf});
        end
        rst0 = 1'b0; v0 = 1'b0;

        // Odd parity: reset value and a single-word frame
        chk("odd_reset_par", {31'd0, par1}, 32'd1);
        v1 = 1'b1; data1 = 8'h01; last1 = 1'b1;
        tick();
        v1 = 1'b0; last1 = 1'b0;
        chk("odd_single", {19'd0, ov1, sum1, par1, cnt1, ovf1}, {19'd0, 1'b1, 8'h01, 1'b0, 3'd1, 1'b0});
        tick();
        chk("odd_release", {31'd0, ov1}, 32'd0);

        // 2-bit variant with a two-word limit
        send2(2'b11, 1'b0);
        chk("w2_mid", {31'd0, ov2}, 32'd0);
        send2(2'b00, 1'b1);
        chk("w2_f0", {25'd0, ov2, sum2, par2, cnt2, ovf2}, {25'd0, 1'b1, 2'b11, 1'b0, 2'd2, 1'b0});
        tick();
        send2(2'b10, 1'b0);
        send2(2'b01, 1'b1);
        chk("w2_f1", {25'd0, ov2, sum2, par2, cnt2, ovf2}, {25'd0, 1'b1, 2'b11, 1'b0, 2'd2, 1'b0});
        tick();
        send2(2'b11, 1'b1);
        chk("w2_f2", {25'd0, ov2, sum2, par2, cnt2, ovf2}, {25'd0, 1'b1, 2'b11, 1'b0, 2'd1, 1'b0});
        tick();
        send2(2'b01, 1'b1);
        chk("w2_f3", {25'd0, ov2, sum2, par2, cnt2, ovf2}, {25'd0, 1'b1, 2'b01, 1'b1, 2'd1, 1'b0});
        tick();
        send2(2'b10, 1'b0);
        send2(2'b10, 1'b0);
        chk("w2_ovf", {25'd0, ov2, sum2, par2, cnt2, ovf2}, {25'd0, 1'b1, 2'b00, 1'b0, 2'd2, 1'b1});
        tick();
        chk("w2_release", {30'd0, ov2, rdy2}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
